// File: rtl/router_pkg.sv
// Shared constants for the reduction-tree router: default layer parameters and the
// derived word width W, plus the SEL direction encoding.
package router_pkg;

  localparam int unsigned K_DEF          = 3;
  localparam int unsigned BOTTLENECK_DEF = 1668;
  localparam int unsigned BIT_OFM_DEF    = 29;
  localparam int unsigned DELTA_X_DEF    = 16;
  localparam int unsigned OU_DEF         = 8;
  localparam int unsigned OUT_CH_DEF     = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 2;

  function automatic int unsigned calc_num_cycle(input int unsigned bottleneck,
                                                 input int unsigned ou,
                                                 input int unsigned delta_x);
    return (bottleneck * ou) / delta_x;
  endfunction

  function automatic int unsigned calc_data_amount(input int unsigned k,
                                                   input int unsigned out_ch);
    return k * out_ch;
  endfunction

  // Pixels that must fit in one word per bottleneck interval (ceiling division).
  function automatic int unsigned calc_how_many_pixel(input int unsigned data_amount,
                                                      input int unsigned num_cycle);
    return (data_amount + num_cycle - 1) / num_cycle;
  endfunction

  function automatic int unsigned calc_w(input int unsigned k,
                                         input int unsigned bottleneck,
                                         input int unsigned bit_ofm,
                                         input int unsigned delta_x,
                                         input int unsigned ou,
                                         input int unsigned out_ch);
    return calc_how_many_pixel(calc_data_amount(k, out_ch),
                               calc_num_cycle(bottleneck, ou, delta_x)) * bit_ofm;
  endfunction

  localparam int unsigned NUM_CYCLE      = calc_num_cycle(BOTTLENECK_DEF, OU_DEF, DELTA_X_DEF);
  localparam int unsigned DATA_AMOUNT    = calc_data_amount(K_DEF, OUT_CH_DEF);
  localparam int unsigned HOW_MANY_PIXEL = calc_how_many_pixel(DATA_AMOUNT, NUM_CYCLE);
  localparam int unsigned W              = HOW_MANY_PIXEL * BIT_OFM_DEF;

  typedef enum logic {
    SelMerge = 1'b0,
    SelSplit = 1'b1
  } sel_e;

endpackage

// File: rtl/router_fifo.sv
// Small circular FIFO with count; pushes while full are dropped even if a pop
// happens on the same edge.
module router_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  // Acceptance looks only at the registered count, never at a same-edge pop.
  assign w_push_ok = i_push && (r_count != FullCnt);
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/router.sv
// Reduction-tree node router: merges two W-bit branch streams onto a 2W trunk
// (SEL=0) or splits the trunk onto the branches (SEL=1).
module router
  import router_pkg::*;
#(
  parameter int unsigned K          = K_DEF,
  parameter int unsigned BOTTLENECK = BOTTLENECK_DEF,
  parameter int unsigned BIT_OFM    = BIT_OFM_DEF,
  parameter int unsigned DELTA_X    = DELTA_X_DEF,
  parameter int unsigned OU         = OU_DEF,
  parameter int unsigned OUT_CH     = OUT_CH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned WD        = calc_w(K, BOTTLENECK, BIT_OFM, DELTA_X, OU, OUT_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SEL,
  input  logic [WD-1:0]   INPUT_BRANCH_1,
  input  logic [WD-1:0]   INPUT_BRANCH_2,
  input  logic [2*WD-1:0] INPUT_TRUNK,
  input  logic            INPUT_BRANCH_1_WRITE,
  input  logic            INPUT_BRANCH_2_WRITE,
  input  logic            INPUT_TRUNK_WRITE,
  output logic [WD-1:0]   output_branch_1,
  output logic [WD-1:0]   output_branch_2,
  output logic [2*WD-1:0] output_trunk,
  output logic            output_branch_1_valid,
  output logic            output_branch_2_valid,
  output logic            output_trunk_valid,
  output logic            input_branch_1_full,
  output logic            input_branch_2_full,
  output logic            input_trunk_full
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(FIFO_DEPTH);

  logic [WD-1:0]   w_b1_data;
  logic [WD-1:0]   w_b2_data;
  logic [2*WD-1:0] w_t_data;
  logic            w_b1_empty;
  logic            w_b2_empty;
  logic            w_t_empty;
  logic [CntW-1:0] w_b1_count;
  logic [CntW-1:0] w_b2_count;
  logic [CntW-1:0] w_t_count;
  logic            w_merge_pop;
  logic            w_split_pop;
  sel_e            w_sel;

  logic [2*WD-1:0] r_trunk;
  logic [WD-1:0]   r_branch_1;
  logic [WD-1:0]   r_branch_2;
  logic            r_trunk_valid;
  logic            r_branch_valid;

  assign w_sel = sel_e'(SEL);

  // Merge only fires when both branches can contribute a half of the trunk word.
  assign w_merge_pop = (w_sel == SelMerge) && !w_b1_empty && !w_b2_empty;
  assign w_split_pop = (w_sel == SelSplit) && !w_t_empty;

  router_fifo #(
    .WIDTH (WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_b1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (INPUT_BRANCH_1_WRITE),
    .i_pop   (w_merge_pop),
    .i_data  (INPUT_BRANCH_1),
    .o_data  (w_b1_data),
    .o_full  (input_branch_1_full),
    .o_empty (w_b1_empty),
    .o_count (w_b1_count)
  );

  router_fifo #(
    .WIDTH (WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_b2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (INPUT_BRANCH_2_WRITE),
    .i_pop   (w_merge_pop),
    .i_data  (INPUT_BRANCH_2),
    .o_data  (w_b2_data),
    .o_full  (input_branch_2_full),
    .o_empty (w_b2_empty),
    .o_count (w_b2_count)
  );

  router_fifo #(
    .WIDTH (2 * WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_t (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (INPUT_TRUNK_WRITE),
    .i_pop   (w_split_pop),
    .i_data  (INPUT_TRUNK),
    .o_data  (w_t_data),
    .o_full  (input_trunk_full),
    .o_empty (w_t_empty),
    .o_count (w_t_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trunk        <= '0;
      r_branch_1     <= '0;
      r_branch_2     <= '0;
      r_trunk_valid  <= 1'b0;
      r_branch_valid <= 1'b0;
    end else begin
      r_trunk_valid  <= w_merge_pop;
      r_branch_valid <= w_split_pop;
      if (w_merge_pop) begin
        r_trunk <= {w_b2_data, w_b1_data};
      end
      if (w_split_pop) begin
        r_branch_1 <= w_t_data[WD-1:0];
        r_branch_2 <= w_t_data[2*WD-1:WD];
      end
    end
  end

  assign output_trunk          = r_trunk;
  assign output_branch_1       = r_branch_1;
  assign output_branch_2       = r_branch_2;
  assign output_trunk_valid    = r_trunk_valid;
  assign output_branch_1_valid = r_branch_valid;
  assign output_branch_2_valid = r_branch_valid;

  // Occupancy can never exceed the depth, and only one direction is ever active.
  a_b1_cnt : assert property (@(posedge clk) disable iff (!rst_n) w_b1_count <= MaxCnt);
  a_b2_cnt : assert property (@(posedge clk) disable iff (!rst_n) w_b2_count <= MaxCnt);
  a_t_cnt  : assert property (@(posedge clk) disable iff (!rst_n) w_t_count <= MaxCnt);
  a_excl   : assert property (@(posedge clk) disable iff (!rst_n)
                              !(r_trunk_valid && r_branch_valid));

endmodule

// File: tb/tb_router.sv
// Scoreboard bench for router: a queue-based FIFO model predicts each output word
// at the driving edge; outputs are compared on the falling edge.
module tb_router;
  import router_pkg::*;

  localparam int unsigned Depth = FIFO_DEPTH_DEF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sel;
  logic [W-1:0]    in_b1, in_b2;
  logic [2*W-1:0]  in_t;
  logic            wr_b1, wr_b2, wr_t;
  logic [W-1:0]    out_b1, out_b2;
  logic [2*W-1:0]  out_t;
  logic            v_b1, v_b2, v_t;
  logic            full_b1, full_b2, full_t;

  logic [W-1:0]    m_b1[$];
  logic [W-1:0]    m_b2[$];
  logic [2*W-1:0]  m_t[$];
  logic [2*W-1:0]  exp_trunk_q[$];
  logic [2*W-1:0]  exp_split_q[$];
  logic [2*W-1:0]  last_trunk, last_split;
  bit              exp_tv, exp_bv;
  int              n_vec, n_err, tv_cnt, bv_cnt;

  always #5 clk = ~clk;

  router dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .SEL                   (sel),
    .INPUT_BRANCH_1        (in_b1),
    .INPUT_BRANCH_2        (in_b2),
    .INPUT_TRUNK           (in_t),
    .INPUT_BRANCH_1_WRITE  (wr_b1),
    .INPUT_BRANCH_2_WRITE  (wr_b2),
    .INPUT_TRUNK_WRITE     (wr_t),
    .output_branch_1       (out_b1),
    .output_branch_2       (out_b2),
    .output_trunk          (out_t),
    .output_branch_1_valid (v_b1),
    .output_branch_2_valid (v_b2),
    .output_trunk_valid    (v_t),
    .input_branch_1_full   (full_b1),
    .input_branch_2_full   (full_b2),
    .input_trunk_full      (full_t)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_b1.delete();
    m_b2.delete();
    m_t.delete();
    exp_trunk_q.delete();
    exp_split_q.delete();
    exp_tv     = 1'b0;
    exp_bv     = 1'b0;
    last_trunk = '0;
    last_split = '0;
  endtask

  // Mirrors one rising edge: pops use pre-edge occupancy, pushes use pre-pop occupancy.
  task automatic model_edge();
    int s1, s2, st;
    logic [W-1:0] h1, h2;
    s1 = m_b1.size();
    s2 = m_b2.size();
    st = m_t.size();
    exp_tv = (sel == 1'b0) && (s1 > 0) && (s2 > 0);
    exp_bv = (sel == 1'b1) && (st > 0);
    if (exp_tv) begin
      h1 = m_b1.pop_front();
      h2 = m_b2.pop_front();
      exp_trunk_q.push_back({h2, h1});
    end
    if (exp_bv) exp_split_q.push_back(m_t.pop_front());
    if (wr_b1 && s1 < int'(Depth)) m_b1.push_back(in_b1);
    if (wr_b2 && s2 < int'(Depth)) m_b2.push_back(in_b2);
    if (wr_t && st < int'(Depth)) m_t.push_back(in_t);
  endtask

  task automatic sample();
    check_eq("trunk_valid", 64'(v_t), 64'(exp_tv));
    check_eq("b1_valid", 64'(v_b1), 64'(exp_bv));
    check_eq("b2_valid", 64'(v_b2), 64'(exp_bv));
    if (v_t && exp_trunk_q.size() > 0) last_trunk = exp_trunk_q.pop_front();
    if (v_b1 && exp_split_q.size() > 0) last_split = exp_split_q.pop_front();
    check_eq("trunk_data", 64'(out_t), 64'(last_trunk));
    check_eq("b1_data", 64'(out_b1), 64'(last_split[W-1:0]));
    check_eq("b2_data", 64'(out_b2), 64'(last_split[2*W-1:W]));
    check_eq("b1_full", 64'(full_b1), 64'(m_b1.size() == int'(Depth)));
    check_eq("b2_full", 64'(full_b2), 64'(m_b2.size() == int'(Depth)));
    check_eq("t_full", 64'(full_t), 64'(m_t.size() == int'(Depth)));
    if (v_t) tv_cnt++;
    if (v_b1) bv_cnt++;
  endtask

  // Entered and left on a falling edge.
  task automatic step(input logic s, input logic p1, input logic [W-1:0] d1,
                      input logic p2, input logic [W-1:0] d2,
                      input logic pt, input logic [2*W-1:0] dt);
    sel = s; wr_b1 = p1; in_b1 = d1; wr_b2 = p2; in_b2 = d2; wr_t = pt; in_t = dt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_outs"}, {6'(0), out_t}, 64'(0));
    check_eq({tag, "_bouts"}, 64'({out_b2, out_b1}), 64'(0));
    check_eq({tag, "_valids"}, 64'({v_t, v_b1, v_b2}), 64'(0));
    check_eq({tag, "_fulls"}, 64'({full_b1, full_b2, full_t}), 64'(0));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; sel = 1'b0;
    wr_b1 = 1'b0; wr_b2 = 1'b0; wr_t = 1'b0;
    in_b1 = '0; in_b2 = '0; in_t = '0;
    model_reset();
    #1 check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst1");
    rst_n = 1'b1;

    // Merge: one paired word two edges after the push.
    tv_cnt = 0;
    step(1'b0, 1'b1, 29'h1, 1'b1, 29'h2, 1'b0, '0);
    idle(1'b0, 3);
    check_eq("merge_word", 64'(out_t), 64'({29'h2, 29'h1}));
    check_eq("merge_pulses", 64'(tv_cnt), 64'(1));

    // Split.
    bv_cnt = 0;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, {29'h1ABCDEF, 29'h0123456});
    idle(1'b1, 3);
    check_eq("split_b1", 64'(out_b1), 64'(29'h0123456));
    check_eq("split_b2", 64'(out_b2), 64'(29'h1ABCDEF));
    check_eq("split_pulses", 64'(bv_cnt), 64'(1));

    // Full and drop while branches are the inactive direction.
    tv_cnt = 0;
    step(1'b1, 1'b1, 29'h10, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 29'h11, 1'b0, '0, 1'b0, '0);
    check_eq("b1_full_after2", 64'(full_b1), 64'(1));
    step(1'b1, 1'b1, 29'h12, 1'b0, '0, 1'b0, '0);
    check_eq("b1_full_after3", 64'(full_b1), 64'(1));
    step(1'b0, 1'b0, '0, 1'b1, 29'h20, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 29'h21, 1'b0, '0);
    idle(1'b0, 3);
    check_eq("drop_pulses", 64'(tv_cnt), 64'(2));
    check_eq("drop_last", 64'(out_t), 64'({29'h21, 29'h11}));

    // Unpaired branch waits for its partner.
    tv_cnt = 0;
    step(1'b0, 1'b1, 29'h30, 1'b0, '0, 1'b0, '0);
    idle(1'b0, 4);
    check_eq("unpaired_none", 64'(tv_cnt), 64'(0));
    step(1'b0, 1'b0, '0, 1'b1, 29'h40, 1'b0, '0);
    idle(1'b0, 2);
    check_eq("unpaired_pair", 64'(tv_cnt), 64'(1));
    check_eq("unpaired_word", 64'(out_t), 64'({29'h40, 29'h30}));

    // Streaming split, then asynchronous reset while a word is valid.
    bv_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, {W'(32'h100 + i), W'(i)});
    end
    check_eq("stream_pulses", 64'(bv_cnt), 64'(10));
    check_eq("stream_valid_pre_rst", 64'(v_b1), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bv_cnt = 0;
    idle(1'b1, 3);
    check_eq("post_rst_pulses", 64'(bv_cnt), 64'(0));

    // Random mix with SEL toggling; the model tracks every FIFO.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 1)), {W'($urandom), W'($urandom)});
    end
    idle(1'b0, 2);
    idle(1'b1, 2);
    check_eq("sb_trunk_left", 64'(exp_trunk_q.size()), 64'(0));
    check_eq("sb_split_left", 64'(exp_split_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
